bcd_counter_ctrl: RTL and testbench
===================================

// Module: bcd_counter_ctrl
// PURPOSE
//   Parametrised N-digit BCD up/down counter with run/pause/done control, internal tick divider,
//   preset load and terminal-count buzzer. It is the counting core between the debouncer/state
//   pulses and seg7_control. It generalises the fixed 0..99 counter to DIGITS digits, with
//   selectable wrap or stop-at-terminal mode and a timed buzzer pulse.
// PARAMETERS
//   DIGITS      4           number of BCD digits (1..8); count range 0 .. 10^DIGITS-1
//   CLK_HZ      50_000_000  input clock frequency
//   TICK_HZ     1           count rate while running; divider period P = CLK_HZ/TICK_HZ cycles
//   WRAP        1           1: roll over at terminal and keep running; 0: hold value, enter DONE
//   BUZZ_CYCLES 25_000_000  buzzer high time in clocks per terminal event
// PORTS
//   clk_50MHz    in   1         system clock; every register updates on its rising edge
//   reset_button in   1         synchronous, active-low reset
//   start_p      in   1         1-cycle start pulse (debounced)
//   stop_p       in   1         1-cycle stop/pause pulse (debounced)
//   load_p       in   1         1-cycle load pulse: copy load_bcd into count
//   clear_p      in   1         1-cycle clear pulse: count := 0, go IDLE
//   updown       in   1         1 = count up, 0 = count down; sampled on each tick
//   load_bcd     in   4*DIGITS  preset value, digit 0 in [3:0]
//   bcd          out  4*DIGITS  current count, digit 0 in [3:0], always valid BCD
//   running      out  1         high in RUN
//   done         out  1         high in DONE (WRAP=0 only)
//   tick         out  1         1-cycle strobe when a count step occurs
//   buzzer       out  1         high for BUZZ_CYCLES after a terminal event
// BEHAVIOUR
//   Reset (reset_button=0 at clk edge): state=IDLE, bcd=0, divider=0, buzz timer=0;
//     running=0, done=0, tick=0, buzzer=0.
//   FSM: IDLE -start_p-> RUN; RUN -stop_p-> PAUSE; PAUSE -start_p-> RUN;
//     RUN -terminal & WRAP=0-> DONE; DONE -start_p-> DONE (no effect); any -clear_p-> IDLE.
//   Pulse priority in the same cycle: clear_p > load_p > stop_p > start_p.
//   load_p: legal in every state; the state is unchanged except DONE -> PAUSE. Each digit >9
//     saturates to 9. The divider restarts at 0. bcd shows the new value next cycle.
//   Divider counts 0..P-1 only in RUN. It holds in PAUSE/IDLE/DONE and restarts at 0 on
//     entering RUN. tick=1 in the cycle the divider is at P-1; bcd updates on that same edge,
//     so the first step comes P cycles after the start_p edge.
//   Up step: BCD increment with ripple carry (9 -> 0, carry to the next digit).
//   Down step: BCD decrement with borrow (0 -> 9).
//   Terminal event: step up from all-9s, or step down from all-0s.
//     WRAP=1: count wraps (all-9s -> 0 / 0 -> all-9s) and stays in RUN.
//     WRAP=0: count holds its value and the state becomes DONE.
//   Buzzer: a terminal event loads the timer with BUZZ_CYCLES; buzzer=1 while timer != 0.
//     A retrigger reloads the timer. clear_p and reset force buzzer=0.
//   updown may change at any time; only its value at the tick edge matters.
//   start_p or stop_p in a state with no matching transition is ignored.
//   Reset mid-count or mid-buzz takes effect on the next edge; it overrides all pulses.
// TESTING (bench params: DIGITS=2, CLK_HZ=10, TICK_HZ=1 so P=10, BUZZ_CYCLES=5)
//   1 reset low 2 cycles -> bcd=8'h00, running=0, done=0, buzzer=0; hold no pulses -> no tick.
//   2 start_p, updown=1, run 25 steps -> bcd=8'h25; ticks exactly 10 cycles apart; first tick
//     10 cycles after start_p.
//   3 load 8'h98, start, up, WRAP=1 -> 99, then 00; buzzer high exactly 5 cycles; running stays 1.
//   4 WRAP=0, load 8'h01, down -> 00, then DONE: bcd holds 00, done=1, running=0;
//     start_p ignored; load 8'h50 -> PAUSE; start_p -> RUN.
//   5 stop_p mid-period (divider=4), wait 30 cycles -> bcd frozen; start_p -> next tick after 10
//     cycles; load 8'hF3 -> bcd=8'h93.
//   6 same-cycle clear_p+load_p+start_p -> IDLE, bcd=00; reset_button low during buzz ->
//     buzzer=0 next cycle.

Source files
------------

// File: rtl/bcd_counter_ctrl.sv
// N-digit BCD up/down counter with run/pause/done control, tick divider,
// preset load and a timed terminal-count buzzer.
module bcd_counter_ctrl #(
    parameter int unsigned DIGITS      = 4,
    parameter int unsigned CLK_HZ      = 50_000_000,
    parameter int unsigned TICK_HZ     = 1,
    parameter int unsigned WRAP        = 1,
    parameter int unsigned BUZZ_CYCLES = 25_000_000
) (
    input  logic                  clk_50MHz,
    input  logic                  reset_button,
    input  logic                  start_p,
    input  logic                  stop_p,
    input  logic                  load_p,
    input  logic                  clear_p,
    input  logic                  updown,
    input  logic [4*DIGITS-1:0]   load_bcd,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  running,
    output logic                  done,
    output logic                  tick,
    output logic                  buzzer
);

    localparam int unsigned W        = 4 * DIGITS;
    localparam int unsigned P_RAW    = CLK_HZ / TICK_HZ;
    localparam int unsigned P        = (P_RAW > 0) ? P_RAW : 1;
    localparam int unsigned DIV_W    = (P > 1) ? $clog2(P) : 1;
    localparam int unsigned BUZZ_W   = (BUZZ_CYCLES > 1) ? $clog2(BUZZ_CYCLES + 1) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(P - 1);
    localparam logic [BUZZ_W-1:0] BUZZ_LOAD = BUZZ_W'(BUZZ_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [W-1:0]        bcd_q, bcd_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [BUZZ_W-1:0]   timer_q, timer_d;
    logic                running_q, done_q, tick_q, buzzer_q;
    logic                step;
    logic                terminal;
    logic                hold_done;

    // BCD increment with ripple carry; all-9s rolls to 0
    function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (c) begin
                if (v[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    c           = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // BCD decrement with ripple borrow; 0 rolls to all-9s
    function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         b;
        r = v;
        b = 1'b1;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (b) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    b           = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [W-1:0] bcd_saturate(input logic [W-1:0] v);
        logic [W-1:0] r;
        r = v;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (v[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd9;
        end
        return r;
    endfunction

    function automatic logic all_digits(input logic [W-1:0] v, input logic [3:0] d);
        logic same;
        same = 1'b1;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (v[4*i +: 4] != d) same = 1'b0;
        end
        return same;
    endfunction

    // State and datapath registers; outputs are registered from next-state values
    always_ff @(posedge clk_50MHz) begin
        if (!reset_button) begin
            state_q   <= S_IDLE;
            bcd_q     <= '0;
            div_q     <= '0;
            timer_q   <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
            tick_q    <= 1'b0;
            buzzer_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            bcd_q     <= bcd_d;
            div_q     <= div_d;
            timer_q   <= timer_d;
            running_q <= (state_d == S_RUN);
            done_q    <= (state_d == S_DONE);
            tick_q    <= (state_d == S_RUN) && (div_d == DIV_LAST);
            buzzer_q  <= (timer_d != '0);
        end
    end

    // Next-state: only the highest-priority pulse (clear > load > stop > start) acts
    always_comb begin
        state_d   = state_q;
        bcd_d     = bcd_q;
        div_d     = div_q;
        timer_d   = (timer_q != '0) ? (timer_q - BUZZ_W'(1)) : '0;
        step      = (state_q == S_RUN) && (div_q == DIV_LAST);
        terminal  = 1'b0;
        hold_done = 1'b0;

        if (clear_p) begin
            state_d = S_IDLE;
            bcd_d   = '0;
            div_d   = '0;
            timer_d = '0;
        end else if (load_p) begin
            bcd_d = bcd_saturate(load_bcd);
            div_d = '0;
            if (state_q == S_DONE) state_d = S_PAUSE;
        end else begin
            if (state_q == S_RUN) begin
                div_d = step ? '0 : (div_q + DIV_W'(1));
            end

            if (step) begin
                terminal = updown ? all_digits(bcd_q, 4'd9) : all_digits(bcd_q, 4'd0);
                if (terminal) timer_d = BUZZ_LOAD;
                if (terminal && (WRAP == 0)) begin
                    hold_done = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    bcd_d = updown ? bcd_inc(bcd_q) : bcd_dec(bcd_q);
                end
            end

            if (!hold_done) begin
                case (state_q)
                    S_IDLE, S_PAUSE: begin
                        if (start_p && !stop_p) begin
                            state_d = S_RUN;
                            div_d   = '0;
                        end
                    end
                    S_RUN: begin
                        if (stop_p) state_d = S_PAUSE;
                    end
                    S_DONE: begin
                        state_d = S_DONE;
                    end
                    default: begin
                        state_d = S_IDLE;
                    end
                endcase
            end
        end
    end

    assign bcd     = bcd_q;
    assign running = running_q;
    assign done    = done_q;
    assign tick    = tick_q;
    assign buzzer  = buzzer_q;

endmodule

// File: tb/tb_bcd_counter_ctrl.sv
// Self-checking bench: two counters (index 0 stops at terminal, index 1 wraps)
// against a decimal reference model through a per-cycle scoreboard queue.
module tb_bcd_counter_ctrl;

    localparam int P    = 10;
    localparam int BUZZ = 5;
    localparam int MAXV = 99;
    localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_DONE = 3;

    logic            clk = 1'b0;
    logic            reset_button;
    logic [1:0]      start_p, stop_p, load_p, clear_p, updown;
    logic [1:0][7:0] load_bcd;
    logic [1:0][7:0] bcd;
    logic [1:0]      running, done, tick, buzzer;

    always #5 clk = ~clk;

    bcd_counter_ctrl #(.DIGITS(2), .CLK_HZ(10), .TICK_HZ(1), .WRAP(0), .BUZZ_CYCLES(5)) u_nowrap (
        .clk_50MHz(clk), .reset_button(reset_button),
        .start_p(start_p[0]), .stop_p(stop_p[0]), .load_p(load_p[0]), .clear_p(clear_p[0]),
        .updown(updown[0]), .load_bcd(load_bcd[0]), .bcd(bcd[0]),
        .running(running[0]), .done(done[0]), .tick(tick[0]), .buzzer(buzzer[0])
    );

    bcd_counter_ctrl #(.DIGITS(2), .CLK_HZ(10), .TICK_HZ(1), .WRAP(1), .BUZZ_CYCLES(5)) u_wrap (
        .clk_50MHz(clk), .reset_button(reset_button),
        .start_p(start_p[1]), .stop_p(stop_p[1]), .load_p(load_p[1]), .clear_p(clear_p[1]),
        .updown(updown[1]), .load_bcd(load_bcd[1]), .bcd(bcd[1]),
        .running(running[1]), .done(done[1]), .tick(tick[1]), .buzzer(buzzer[1])
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    int m_val[2] = '{0, 0};
    int m_st[2]  = '{0, 0};
    int m_div[2] = '{0, 0};
    int m_tmr[2] = '{0, 0};

    logic [23:0] sb_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference model advance for one clock edge, from the inputs currently driven
    task automatic model_step(input int k);
        int  st, val, dv, tn, lo, hi;
        bit  stp, term;
        if (!reset_button) begin
            m_st[k] = S_IDLE; m_val[k] = 0; m_div[k] = 0; m_tmr[k] = 0;
            return;
        end
        st = m_st[k]; val = m_val[k]; dv = m_div[k];
        tn = (m_tmr[k] > 0) ? m_tmr[k] - 1 : 0;
        stp  = (m_st[k] == S_RUN) && (m_div[k] == P - 1);
        term = 1'b0;
        if (clear_p[k]) begin
            st = S_IDLE; val = 0; dv = 0; tn = 0;
        end else if (load_p[k]) begin
            lo = int'(load_bcd[k][3:0]); hi = int'(load_bcd[k][7:4]);
            if (lo > 9) lo = 9;
            if (hi > 9) hi = 9;
            val = hi * 10 + lo;
            dv  = 0;
            if (m_st[k] == S_DONE) st = S_PAUSE;
        end else begin
            if (m_st[k] == S_RUN) dv = stp ? 0 : m_div[k] + 1;
            if (stp) begin
                term = updown[k] ? (m_val[k] == MAXV) : (m_val[k] == 0);
                if (term) tn = BUZZ;
                if (term && k == 0) st = S_DONE;
                else val = updown[k] ? (m_val[k] + 1) % (MAXV + 1) : (m_val[k] + MAXV) % (MAXV + 1);
            end
            if (!(term && k == 0)) begin
                if ((m_st[k] == S_IDLE || m_st[k] == S_PAUSE) && start_p[k] && !stop_p[k]) begin
                    st = S_RUN; dv = 0;
                end else if (m_st[k] == S_RUN && stop_p[k]) begin
                    st = S_PAUSE;
                end
            end
        end
        m_st[k] = st; m_val[k] = val; m_div[k] = dv; m_tmr[k] = tn;
    endtask

    function automatic logic [11:0] model_out(input int k);
        logic [7:0] b;
        b = {4'(m_val[k] / 10), 4'(m_val[k] % 10)};
        return {b, m_st[k] == S_RUN, m_st[k] == S_DONE,
                (m_st[k] == S_RUN) && (m_div[k] == P - 1), m_tmr[k] != 0};
    endfunction

    // One clock: model predicts, expectation queued, DUT observed #1 after the edge
    task automatic step_clk();
        logic [23:0] e;
        model_step(0);
        model_step(1);
        sb_q.push_back({model_out(1), model_out(0)});
        @(posedge clk);
        #1;
        cyc++;
        e = sb_q.pop_front();
        check("sb0", 32'({bcd[0], running[0], done[0], tick[0], buzzer[0]}), 32'(e[11:0]));
        check("sb1", 32'({bcd[1], running[1], done[1], tick[1], buzzer[1]}), 32'(e[23:12]));
        start_p = '0; stop_p = '0; load_p = '0; clear_p = '0;
    endtask

    task automatic run_until_bcd(input int k, input logic [7:0] v, input int max, output int n);
        n = 0;
        while (bcd[k] !== v && n < max) begin
            step_clk();
            n++;
        end
    endtask

    initial begin
        int n, ticks, bad, last_tick, hi;
        reset_button = 1'b0;
        start_p = '0; stop_p = '0; load_p = '0; clear_p = '0; updown = '0;
        load_bcd = '0;

        // Reset and idle
        repeat (2) step_clk();
        check("rst_bcd", 32'(bcd), 32'h0);
        check("rst_flags", 32'({running, done, buzzer}), 32'h0);
        reset_button = 1'b1;
        ticks = 0;
        repeat (15) begin
            step_clk();
            ticks += int'(tick[0]) + int'(tick[1]);
        end
        check("idle_no_tick", 32'(ticks), 32'd0);

        // Count up 25 steps on the wrapping counter
        updown[1] = 1'b1;
        start_p[1] = 1'b1;
        step_clk();
        run_until_bcd(1, 8'h01, 20, n);
        check("first_step_latency", 32'(n), 32'd10);
        n = 0; bad = 0; last_tick = -1;
        while (bcd[1] !== 8'h25 && n < 400) begin
            step_clk();
            n++;
            if (tick[1]) begin
                if (last_tick >= 0 && cyc - last_tick != 10) bad++;
                last_tick = cyc;
            end
        end
        check("cycles_01_to_25", 32'(n), 32'd240);
        check("bcd_25", 32'(bcd[1]), 32'h25);
        check("tick_gaps", 32'(bad), 32'd0);

        // Wrap 98 -> 99 -> 00 with buzzer
        load_bcd[1] = 8'h98; load_p[1] = 1'b1;
        step_clk();
        check("load_98", 32'(bcd[1]), 32'h98);
        run_until_bcd(1, 8'h99, 20, n);
        check("to_99", 32'(n), 32'd10);
        run_until_bcd(1, 8'h00, 20, n);
        check("wrap_to_00", 32'(n), 32'd10);
        check("wrap_running", 32'(running[1]), 32'd1);
        hi = int'(buzzer[1]);
        repeat (9) begin
            step_clk();
            hi += int'(buzzer[1]);
        end
        check("buzz_len", 32'(hi), 32'd5);
        check("wrap_still_running", 32'(running[1]), 32'd1);
        stop_p[1] = 1'b1;
        step_clk();
        check("stopped", 32'(running[1]), 32'd0);

        // Stop-at-terminal counter: 01 down to 00, then DONE
        updown[0] = 1'b0;
        load_bcd[0] = 8'h01; load_p[0] = 1'b1;
        step_clk();
        start_p[0] = 1'b1;
        step_clk();
        run_until_bcd(0, 8'h00, 20, n);
        check("down_to_00", 32'(n), 32'd10);
        n = 0;
        while (!done[0] && n < 20) begin
            step_clk();
            n++;
        end
        check("done_latency", 32'(n), 32'd10);
        check("done_bcd", 32'(bcd[0]), 32'h00);
        check("done_flags", 32'({running[0], done[0], buzzer[0]}), 32'b011);
        start_p[0] = 1'b1;
        step_clk();
        check("done_ignores_start", 32'({running[0], done[0]}), 32'b01);
        load_bcd[0] = 8'h50; load_p[0] = 1'b1;
        step_clk();
        check("load_from_done", 32'({bcd[0], running[0], done[0]}), 32'({8'h50, 2'b00}));
        start_p[0] = 1'b1;
        step_clk();
        check("pause_to_run", 32'(running[0]), 32'd1);

        // Pause mid-period, resume, saturating load
        load_bcd[1] = 8'h40; load_p[1] = 1'b1;
        step_clk();
        start_p[1] = 1'b1;
        step_clk();
        repeat (4) step_clk();
        stop_p[1] = 1'b1;
        step_clk();
        check("paused", 32'(running[1]), 32'd0);
        repeat (30) step_clk();
        check("frozen", 32'(bcd[1]), 32'h40);
        start_p[1] = 1'b1;
        step_clk();
        run_until_bcd(1, 8'h41, 20, n);
        check("resume_latency", 32'(n), 32'd10);
        load_bcd[1] = 8'hF3; load_p[1] = 1'b1;
        step_clk();
        check("load_sat", 32'(bcd[1]), 32'h93);

        // Pulse priority and reset during buzz
        load_bcd[1] = 8'h77;
        clear_p[1] = 1'b1; load_p[1] = 1'b1; start_p[1] = 1'b1;
        step_clk();
        check("clear_wins", 32'({bcd[1], running[1]}), 32'h0);
        load_bcd[0] = 8'h00; load_p[0] = 1'b1;
        step_clk();
        n = 0;
        while (!buzzer[0] && n < 20) begin
            step_clk();
            n++;
        end
        check("buzz_start", 32'(n), 32'd10);
        step_clk();
        check("buzz_active", 32'(buzzer[0]), 32'd1);
        reset_button = 1'b0;
        step_clk();
        check("rst_kills_buzz", 32'({buzzer[0], done[0], bcd[0]}), 32'h0);
        reset_button = 1'b1;
        step_clk();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
